// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame slave and its SPI_Master counterpart.
// Holds the frame FSM state encoding and the default word/frame geometry.
package spi_frame_pkg;

  localparam int unsigned DefWordBits   = 24;
  localparam int unsigned DefFrameWords = 5;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StShift   = 2'd2,
    StWordEnd = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Synchronizer plus edge detect for one asynchronous SPI input.
//   clk_i   : block clock
//   rst_ni  : asynchronous active-low reset (all flops load ResetVal)
//   d_i     : asynchronous input
//   q_o     : synchronized level
//   rise_o  : one-cycle pulse on synchronized 0->1
//   fall_o  : one-cycle pulse on synchronized 1->0
module spi_input_sync #(
  parameter int unsigned SyncStages = 2,
  parameter logic        ResetVal   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_d, sync_q;
  logic                  prev_d, prev_q;

  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < SyncStages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SyncStages-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SyncStages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SyncStages-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-1 (CPOL=0, CPHA=1) frame slave, oversampled by system_clock.
// A frame is FRAME_WORDS words of WORD_BITS bits, MSB first, framed by SPI_CS low.
//   system_clock, reset_n       : block clock, asynchronous active-low reset
//   SPI_SCLK/SPI_CS/SPI_MOSI    : asynchronous SPI inputs
//   SPI_MISO                    : slave data out, forced 0 while CS is high
//   tx_word / tx_load           : next word to send, captured while tx_load=1
//   rx_word / rx_valid          : last complete received word, with update pulse
//   word_index                  : index of the word currently shifting
//   frame_done / frame_abort    : end-of-frame pulses (complete / cut short)
module spi_frame_slave
  import spi_frame_pkg::*;
#(
  parameter int unsigned WORD_BITS   = DefWordBits,
  parameter int unsigned FRAME_WORDS = DefFrameWords,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                             system_clock,
  input  logic                             reset_n,
  input  logic                             SPI_SCLK,
  input  logic                             SPI_CS,
  input  logic                             SPI_MOSI,
  output logic                             SPI_MISO,
  input  logic [WORD_BITS-1:0]             tx_word,
  output logic                             tx_load,
  output logic [WORD_BITS-1:0]             rx_word,
  output logic                             rx_valid,
  output logic [$clog2(FRAME_WORDS)-1:0]   word_index,
  output logic                             frame_done,
  output logic                             frame_abort
);

  localparam int unsigned CntW = $clog2(WORD_BITS + 1);
  localparam int unsigned IdxW = $clog2(FRAME_WORDS);
  localparam logic [CntW-1:0] LastBit  = CntW'(WORD_BITS - 1);
  localparam logic [IdxW-1:0] LastWord = IdxW'(FRAME_WORDS - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_input_sync #(.SyncStages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk_i (system_clock), .rst_ni(reset_n), .d_i(SPI_SCLK),
    .q_o   (sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_input_sync #(.SyncStages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
    .clk_i (system_clock), .rst_ni(reset_n), .d_i(SPI_CS),
    .q_o   (cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_input_sync #(.SyncStages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk_i (system_clock), .rst_ni(reset_n), .d_i(SPI_MOSI),
    .q_o   (mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  spi_state_e            state_d, state_q;
  logic [WORD_BITS-1:0]  tx_sr_d, tx_sr_q;
  logic [WORD_BITS-1:0]  rx_sr_d, rx_sr_q;
  logic [WORD_BITS-1:0]  rx_word_d, rx_word_q;
  logic [CntW-1:0]       bit_cnt_d, bit_cnt_q;
  logic [IdxW-1:0]       word_idx_d, word_idx_q;
  logic                  miso_d, miso_q;
  logic                  rx_valid_d, rx_valid_q;
  logic                  frame_done_d, frame_done_q;
  logic                  frame_abort_d, frame_abort_q;
  logic                  cs_armed_d, cs_armed_q;
  logic [SYNC_STAGES:0]  flush_d, flush_q;
  logic                  word_done;

  logic unused_sync;
  assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall, rx_sr_q[WORD_BITS-1]};

  // The CS chain resets to "high", so right after reset it can show a false
  // fall. Frames are only accepted once CS has been seen high on a flushed
  // chain; a CS held low through reset must be released first.
  assign flush_d    = {flush_q[SYNC_STAGES-1:0], 1'b1};
  assign cs_armed_d = cs_armed_q | (flush_q[SYNC_STAGES] & cs_s);

  always_comb begin
    state_d       = state_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    rx_word_d     = rx_word_q;
    bit_cnt_d     = bit_cnt_q;
    word_idx_d    = word_idx_q;
    miso_d        = miso_q;
    rx_valid_d    = 1'b0;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    word_done     = 1'b0;

    case (state_q)
      StIdle: begin
        miso_d     = 1'b0;
        bit_cnt_d  = '0;
        word_idx_d = '0;
        if (cs_fall && cs_armed_q) begin
          state_d = StLoad;
        end
      end

      StLoad: begin
        tx_sr_d   = tx_word;
        bit_cnt_d = '0;
        if (cs_rise) begin
          state_d       = StIdle;
          word_idx_d    = '0;
          miso_d        = 1'b0;
          frame_abort_d = 1'b1;
        end else begin
          state_d = StShift;
        end
      end

      StShift: begin
        if (sclk_rise) begin
          miso_d  = tx_sr_q[WORD_BITS-1];
          tx_sr_d = {tx_sr_q[WORD_BITS-2:0], 1'b0};
        end
        if (sclk_fall) begin
          rx_sr_d   = {rx_sr_q[WORD_BITS-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == LastBit) begin
            word_done  = 1'b1;
            rx_word_d  = rx_sr_d;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            state_d    = StWordEnd;
          end
        end
        // A word finishing on the same edge as CS release is still reported.
        if (cs_rise) begin
          state_d    = StIdle;
          word_idx_d = '0;
          miso_d     = 1'b0;
          if (word_done && (word_idx_q == LastWord)) begin
            frame_done_d = 1'b1;
          end else begin
            frame_abort_d = 1'b1;
          end
        end
      end

      StWordEnd: begin
        if (word_idx_q == LastWord) begin
          frame_done_d = 1'b1;
          word_idx_d   = '0;
          miso_d       = 1'b0;
          state_d      = StIdle;
        end else if (cs_rise) begin
          frame_abort_d = 1'b1;
          word_idx_d    = '0;
          miso_d        = 1'b0;
          state_d       = StIdle;
        end else begin
          word_idx_d = word_idx_q + IdxW'(1);
          state_d    = StLoad;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      tx_sr_q       <= '0;
      rx_sr_q       <= '0;
      rx_word_q     <= '0;
      bit_cnt_q     <= '0;
      word_idx_q    <= '0;
      miso_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      cs_armed_q    <= 1'b0;
      flush_q       <= '0;
    end else begin
      state_q       <= state_d;
      tx_sr_q       <= tx_sr_d;
      rx_sr_q       <= rx_sr_d;
      rx_word_q     <= rx_word_d;
      bit_cnt_q     <= bit_cnt_d;
      word_idx_q    <= word_idx_d;
      miso_q        <= miso_d;
      rx_valid_q    <= rx_valid_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      cs_armed_q    <= cs_armed_d;
      flush_q       <= flush_d;
    end
  end

  // Gate on the raw pin so MISO drops as soon as the master deselects.
  assign SPI_MISO    = miso_q & ~SPI_CS;
  assign tx_load     = (state_q == StLoad);
  assign rx_word     = rx_word_q;
  assign rx_valid    = rx_valid_q;
  assign word_index  = word_idx_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

endmodule
